// File: rtl/id_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : id_pkg                                                     |
// | Description : Shared constants, control bundle type and the decode /     |
// |               condition-check functions used by the ID stage.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package id_pkg;

  // EXE unit commands
  localparam logic [3:0] c_CMD_NONE = 4'b0000;
  localparam logic [3:0] c_CMD_MOV  = 4'b0001;
  localparam logic [3:0] c_CMD_ADD  = 4'b0010;
  localparam logic [3:0] c_CMD_ADC  = 4'b0011;
  localparam logic [3:0] c_CMD_SUB  = 4'b0100;
  localparam logic [3:0] c_CMD_SBC  = 4'b0101;
  localparam logic [3:0] c_CMD_AND  = 4'b0110;
  localparam logic [3:0] c_CMD_ORR  = 4'b0111;
  localparam logic [3:0] c_CMD_EOR  = 4'b1000;
  localparam logic [3:0] c_CMD_MVN  = 4'b1001;

  // Data-processing opcodes (instr[24:21])
  localparam logic [3:0] c_OP_AND = 4'b0000;
  localparam logic [3:0] c_OP_EOR = 4'b0001;
  localparam logic [3:0] c_OP_SUB = 4'b0010;
  localparam logic [3:0] c_OP_ADD = 4'b0100;
  localparam logic [3:0] c_OP_ADC = 4'b0101;
  localparam logic [3:0] c_OP_SBC = 4'b0110;
  localparam logic [3:0] c_OP_TST = 4'b1000;
  localparam logic [3:0] c_OP_CMP = 4'b1010;
  localparam logic [3:0] c_OP_ORR = 4'b1100;
  localparam logic [3:0] c_OP_MOV = 4'b1101;
  localparam logic [3:0] c_OP_MVN = 4'b1111;

  // Instruction modes (instr[27:26])
  localparam logic [1:0] c_MODE_DP  = 2'b00;
  localparam logic [1:0] c_MODE_MEM = 2'b01;
  localparam logic [1:0] c_MODE_BR  = 2'b10;

  // Condition codes (instr[31:28])
  localparam logic [3:0] c_COND_EQ = 4'b0000;
  localparam logic [3:0] c_COND_NE = 4'b0001;
  localparam logic [3:0] c_COND_CS = 4'b0010;
  localparam logic [3:0] c_COND_CC = 4'b0011;
  localparam logic [3:0] c_COND_MI = 4'b0100;
  localparam logic [3:0] c_COND_PL = 4'b0101;
  localparam logic [3:0] c_COND_VS = 4'b0110;
  localparam logic [3:0] c_COND_VC = 4'b0111;
  localparam logic [3:0] c_COND_HI = 4'b1000;
  localparam logic [3:0] c_COND_LS = 4'b1001;
  localparam logic [3:0] c_COND_GE = 4'b1010;
  localparam logic [3:0] c_COND_LT = 4'b1011;
  localparam logic [3:0] c_COND_GT = 4'b1100;
  localparam logic [3:0] c_COND_LE = 4'b1101;
  localparam logic [3:0] c_COND_AL = 4'b1110;

  // Control bundle handed to EXE
  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s;
    logic [3:0] exe_cmd;
  } ctrl_t;

  // Maps mode/opcode/S to the control bundle; unknown encodings give all 0.
  function automatic ctrl_t id_decode(input logic [1:0] mode,
                                      input logic [3:0] opcode,
                                      input logic       s_bit);
    ctrl_t c;
    c = '0;
    case (mode)
      c_MODE_DP: begin
        c.wb_en = 1'b1;
        c.s     = s_bit;
        case (opcode)
          c_OP_MOV: c.exe_cmd = c_CMD_MOV;
          c_OP_MVN: c.exe_cmd = c_CMD_MVN;
          c_OP_ADD: c.exe_cmd = c_CMD_ADD;
          c_OP_ADC: c.exe_cmd = c_CMD_ADC;
          c_OP_SUB: c.exe_cmd = c_CMD_SUB;
          c_OP_SBC: c.exe_cmd = c_CMD_SBC;
          c_OP_AND: c.exe_cmd = c_CMD_AND;
          c_OP_ORR: c.exe_cmd = c_CMD_ORR;
          c_OP_EOR: c.exe_cmd = c_CMD_EOR;
          // Compare/test only update flags: no writeback, S forced on
          c_OP_CMP: begin c.exe_cmd = c_CMD_SUB; c.wb_en = 1'b0; c.s = 1'b1; end
          c_OP_TST: begin c.exe_cmd = c_CMD_AND; c.wb_en = 1'b0; c.s = 1'b1; end
          default:  c = '0;
        endcase
      end
      c_MODE_MEM: begin
        // Address generation is always an add; S selects load vs store
        c.exe_cmd  = c_CMD_ADD;
        c.wb_en    = s_bit;
        c.mem_r_en = s_bit;
        c.mem_w_en = ~s_bit;
      end
      c_MODE_BR: c.b = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  // status = {N,Z,C,V}
  function automatic logic id_cond_pass(input logic [3:0] cond,
                                        input logic [3:0] status);
    logic n, z, c, v;
    logic pass;
    n = status[3];
    z = status[2];
    c = status[1];
    v = status[0];
    case (cond)
      c_COND_EQ: pass = z;
      c_COND_NE: pass = ~z;
      c_COND_CS: pass = c;
      c_COND_CC: pass = ~c;
      c_COND_MI: pass = n;
      c_COND_PL: pass = ~n;
      c_COND_VS: pass = v;
      c_COND_VC: pass = ~v;
      c_COND_HI: pass = c & ~z;
      c_COND_LS: pass = ~c | z;
      c_COND_GE: pass = (n == v);
      c_COND_LT: pass = (n != v);
      c_COND_GT: pass = ~z & (n == v);
      c_COND_LE: pass = z | (n != v);
      c_COND_AL: pass = 1'b1;
      default:   pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : id_regfile                                                 |
// | Description : Register file, 2 combinational read ports, 1 write port,   |
// |               optional write-through bypass.                             |
// | Revision    : 1.0 - initial release                                      |
// | Ports       : clk, rst        clock / sync active-high reset             |
// |               i_raddr1/2      read addresses                             |
// |               o_rdata1/2      read data                                  |
// |               i_wen,i_waddr,  write enable / address / data              |
// |               i_wdata                                                    |
// +--------------------------------------------------------------------------+
module id_regfile #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        i_raddr1,
  input  logic [3:0]        i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2,
  input  logic              i_wen,
  input  logic [3:0]        i_waddr,
  input  logic [DATA_W-1:0] i_wdata
);
  import id_pkg::*;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_byp1;
  logic              w_byp2;

  // Writes to unimplemented indices simply match no entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
    end else if (i_wen) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (i_waddr == 4'(k)) r_regs[k] <= i_wdata;
      end
    end
  end

  // Bypass only for implemented indices so out-of-range reads stay 0.
  assign w_byp1 = (BYPASS != 0) && i_wen && (i_waddr == i_raddr1) && (32'(i_raddr1) < NUM_REGS);
  assign w_byp2 = (BYPASS != 0) && i_wen && (i_waddr == i_raddr2) && (32'(i_raddr2) < NUM_REGS);

  always_comb begin
    o_rdata1 = '0;
    o_rdata2 = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (i_raddr1 == 4'(k)) o_rdata1 = r_regs[k];
      if (i_raddr2 == 4'(k)) o_rdata2 = r_regs[k];
    end
    if (w_byp1) o_rdata1 = i_wdata;
    if (w_byp2) o_rdata2 = i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/id_stage_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : id_stage_pipe                                              |
// | Description : Decode stage with condition check, register file and the   |
// |               ID/EX pipeline register.                                   |
// | Revision    : 1.0 - initial release                                      |
// | Ports       : clk, rst            clock / sync active-high reset         |
// |               i_freeze/i_flush/   stall, kill, bubble controls           |
// |               i_hazard                                                   |
// |               i_in_valid/pc/instr IF/ID contents                         |
// |               i_status            {N,Z,C,V}                              |
// |               i_wb_*              writeback port into the register file  |
// |               o_hz_*              combinational source info for hazards  |
// |               o_ex_*              registered bundle to EXE               |
// +--------------------------------------------------------------------------+
module id_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 32,
  parameter int NUM_REGS = 16,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_freeze,
  input  logic              i_flush,
  input  logic              i_hazard,
  input  logic              i_in_valid,
  input  logic [PC_W-1:0]   i_in_pc,
  input  logic [31:0]       i_in_instr,
  input  logic [3:0]        i_status,
  input  logic              i_wb_en,
  input  logic [3:0]        i_wb_dest,
  input  logic [DATA_W-1:0] i_wb_value,
  output logic [3:0]        o_hz_src1,
  output logic [3:0]        o_hz_src2,
  output logic              o_hz_two_src,
  output logic              o_ex_valid,
  output logic              o_ex_wb_en,
  output logic              o_ex_mem_r_en,
  output logic              o_ex_mem_w_en,
  output logic              o_ex_b,
  output logic              o_ex_s,
  output logic              o_ex_imm,
  output logic [3:0]        o_ex_exe_cmd,
  output logic [3:0]        o_ex_dest,
  output logic [3:0]        o_ex_src1,
  output logic [3:0]        o_ex_src2,
  output logic [PC_W-1:0]   o_ex_pc,
  output logic [11:0]       o_ex_shift_operand,
  output logic [23:0]       o_ex_signed_imm_24,
  output logic [DATA_W-1:0] o_ex_val_rn,
  output logic [DATA_W-1:0] o_ex_val_rm
);
  import id_pkg::*;

  // Instruction fields
  logic [3:0]        w_cond;
  logic [1:0]        w_mode;
  logic              w_imm;
  logic [3:0]        w_opcode;
  logic              w_s_bit;
  logic [3:0]        w_rn;
  logic [3:0]        w_rd;
  logic [3:0]        w_rm;
  logic              w_is_str;
  logic [3:0]        w_src2;
  ctrl_t             w_ctrl;
  logic              w_live;
  logic [DATA_W-1:0] w_val_rn;
  logic [DATA_W-1:0] w_val_rm;

  // Pipeline register
  logic              r_ex_valid;
  ctrl_t             r_ex_ctrl;
  logic              r_ex_imm;
  logic [3:0]        r_ex_dest;
  logic [3:0]        r_ex_src1;
  logic [3:0]        r_ex_src2;
  logic [PC_W-1:0]   r_ex_pc;
  logic [11:0]       r_ex_shift_operand;
  logic [23:0]       r_ex_signed_imm_24;
  logic [DATA_W-1:0] r_ex_val_rn;
  logic [DATA_W-1:0] r_ex_val_rm;

  assign w_cond   = i_in_instr[31:28];
  assign w_mode   = i_in_instr[27:26];
  assign w_imm    = i_in_instr[25];
  assign w_opcode = i_in_instr[24:21];
  assign w_s_bit  = i_in_instr[20];
  assign w_rn     = i_in_instr[19:16];
  assign w_rd     = i_in_instr[15:12];
  assign w_rm     = i_in_instr[3:0];

  // A store needs Rd's value as the data to write, so it takes port 2.
  assign w_is_str = (w_mode == c_MODE_MEM) && !w_s_bit;
  assign w_src2   = w_is_str ? w_rd : w_rm;

  assign o_hz_src1    = w_rn;
  assign o_hz_src2    = w_src2;
  assign o_hz_two_src = w_is_str || !w_imm;

  assign w_ctrl = id_decode(w_mode, w_opcode, w_s_bit);
  assign w_live = i_in_valid && !i_hazard && id_cond_pass(w_cond, i_status);

  id_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .BYPASS   (BYPASS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .i_raddr1 (w_rn),
    .i_raddr2 (w_src2),
    .o_rdata1 (w_val_rn),
    .o_rdata2 (w_val_rm),
    .i_wen    (i_wb_en),
    .i_waddr  (i_wb_dest),
    .i_wdata  (i_wb_value)
  );

  // Flush takes precedence over freeze and clears data fields as well.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_ex_valid         <= 1'b0;
      r_ex_ctrl          <= '0;
      r_ex_imm           <= 1'b0;
      r_ex_dest          <= '0;
      r_ex_src1          <= '0;
      r_ex_src2          <= '0;
      r_ex_pc            <= '0;
      r_ex_shift_operand <= '0;
      r_ex_signed_imm_24 <= '0;
      r_ex_val_rn        <= '0;
      r_ex_val_rm        <= '0;
    end else if (!i_freeze) begin
      r_ex_valid         <= w_live;
      r_ex_ctrl          <= w_live ? w_ctrl : '0;
      r_ex_imm           <= w_imm;
      r_ex_dest          <= w_rd;
      r_ex_src1          <= w_rn;
      r_ex_src2          <= w_src2;
      r_ex_pc            <= i_in_pc;
      r_ex_shift_operand <= i_in_instr[11:0];
      r_ex_signed_imm_24 <= i_in_instr[23:0];
      r_ex_val_rn        <= w_val_rn;
      r_ex_val_rm        <= w_val_rm;
    end
  end

  assign o_ex_valid         = r_ex_valid;
  assign o_ex_wb_en         = r_ex_ctrl.wb_en;
  assign o_ex_mem_r_en      = r_ex_ctrl.mem_r_en;
  assign o_ex_mem_w_en      = r_ex_ctrl.mem_w_en;
  assign o_ex_b             = r_ex_ctrl.b;
  assign o_ex_s             = r_ex_ctrl.s;
  assign o_ex_exe_cmd       = r_ex_ctrl.exe_cmd;
  assign o_ex_imm           = r_ex_imm;
  assign o_ex_dest          = r_ex_dest;
  assign o_ex_src1          = r_ex_src1;
  assign o_ex_src2          = r_ex_src2;
  assign o_ex_pc            = r_ex_pc;
  assign o_ex_shift_operand = r_ex_shift_operand;
  assign o_ex_signed_imm_24 = r_ex_signed_imm_24;
  assign o_ex_val_rn        = r_ex_val_rn;
  assign o_ex_val_rm        = r_ex_val_rm;

endmodule
`default_nettype wire

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised decode stage that merges decode, condition check and the register file with the ID/EX pipeline register.
- Adds the following: a registered output bundle with a valid bit, freeze and flush control, write-through register-file bypass, source-address outputs for the hazard and forwarding units, and generic data/PC widths.
- Sits between the IF/ID register and EXE.

Parameters:
- DATA_W, 32, register and operand width.
- PC_W, 32, PC width carried through to EXE.
- NUM_REGS, 16, implemented registers, at most 16. Reads of indices >= NUM_REGS return 0; writes to them are ignored.
- BYPASS, 1, 1 = a WB write to the register being read is visible in the same cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  global stall; hold the output register.
- flush  in  1  branch taken in EXE; kill the current ID instruction.
- hazard  in  1  from the hazard unit; insert a bubble.
- in_valid  in  1  IF/ID holds a real instruction.
- in_pc  in  PC_W  PC+4 of the instruction.
- in_instr  in  32  instruction.
- status  in  4  {N,Z,C,V}.
- wb_en  in  1  WB write enable.
- wb_dest  in  4  WB destination register.
- wb_value  in  DATA_W  WB write data.
- hz_src1, hz_src2  out  4  combinational: Rn, and Rm (Rd for STR).
- hz_two_src  out  1  combinational: decoded STR OR (I==0).
- ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm  out  1 each  registered.
- ex_exe_cmd  out  4  registered.
- ex_dest  out  4  registered.
- ex_src1, ex_src2  out  4  registered, for forwarding.
- ex_pc  out  PC_W  registered.
- ex_shift_operand  out  12  registered.
- ex_signed_imm_24  out  24  registered.
- ex_val_rn, ex_val_rm  out  DATA_W  registered.

Behaviour:
- Instruction fields:
  - cond [31:28], mode [27:26], I [25], opcode [24:21], S [20], Rn [19:16], Rd [15:12].
  - Rm is [3:0]; for stores, Rd is read on the second port instead.
- Decode, for mode 00 (data processing):
  - MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101.
  - AND 0000->0110, ORR 1100->0111, EOR 0001->1000.
  - These all have wb_en=1; ex_s = the S bit.
  - CMP 1010->0100 and TST 1000->0110: wb_en=0, ex_s=1.
- Decode, for mode 01 (memory):
  - S=1 is LDR: cmd 0010, wb_en=1, mem_r_en=1.
  - S=0 is STR: cmd 0010, mem_w_en=1.
- Decode, for mode 10: b=1.
- Any other encoding yields all controls 0.
- Condition check:
  - Codes are the standard EQ..LE and AL=1110; 1111 fails.
  - The check uses the current `status` input.
- Register file:
  - Written on the rising edge when wb_en=1.
  - Reads are combinational.
  - With BYPASS=1 and wb_en=1 and wb_dest equal to the read address, the read returns wb_value.
  - All registers reset to 0.
- Output register update, in priority order each cycle:
  1. rst: every ex_* output is 0.
  2. flush: ex_valid and all controls (wb_en, mem_r_en, mem_w_en, b, s, exe_cmd) are 0. Data fields don't care; they load 0.
  3. freeze: hold all ex_* outputs.
  4. Otherwise load the decoded bundle.
     - Controls and ex_valid are forced to 0 when hazard=1, in_valid=0, or the condition fails.
     - Data fields load unconditionally.
- flush and freeze together: flush wins.
- Register-file writes are not affected by freeze, flush or hazard.
- Latency: one cycle, from IF/ID input to the ex_* outputs.
- hz_* outputs are purely combinational from in_instr and are not gated by in_valid.
- rst in the middle of a stream: the next edge produces a bubble, and the register file is zeroed.

Decomposition:
- Package id_pkg: EXE_CMD constants, opcode constants, mode constants, condition-code constants, and a ctrl bundle struct (wb_en, mem_r_en, mem_w_en, b, s, exe_cmd).
- Sub-module id_regfile (DATA_W, NUM_REGS, BYPASS): 2 read ports and 1 write port.
- Decode and condition check are written as functions in id_pkg.

Test Plan:
- ADD R1,R2,R3 (0xE0821003), R2=5, R3=7, no stall -> next cycle: ex_valid=1, exe_cmd=0010, wb_en=1, val_rn=5, val_rm=7, dest=1, hz_two_src=1.
- Bypass: wb_en=1, wb_dest=2, wb_value=0x99 in the same cycle as a read of R2 -> ex_val_rn=0x99 with BYPASS=1; the old value with BYPASS=0.
- STR R4,[R5,#8] -> hz_src2=4, hz_two_src=1, ex_mem_w_en=1, ex_wb_en=0. LDR with S=1 -> mem_r_en=1, wb_en=1.
- ADDEQ with status Z=0 -> ex_valid=0 and all controls 0. The same instruction with Z=1 -> wb_en=1.
- freeze=1 for 3 cycles while in_instr changes -> ex_* unchanged. Then flush=1 together with freeze=1 -> ex_valid=0 on the next edge.
- hazard=1 -> bubble (controls 0) while ex_pc still loads in_pc. rst asserted mid-stream -> all ex_* 0 after the edge, and a read of R1 returns 0.
